// File: rtl/par_lfsr_source_pkg.sv
// Shared constants and LFSR step function for the pseudo-random NoC traffic source.
package par_lfsr_source_pkg;
  localparam int PAYLOAD_SIZE = 8;
  localparam int ADDR_BITS    = 4;
  localparam int NUM_NODES    = 9;
  localparam int DW           = PAYLOAD_SIZE + ADDR_BITS;
  localparam int CNT_SENT_W   = 20;
  localparam int CNT_DROP_W   = 16;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as state bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/par_lfsr_source_if.sv
// Local injection port between traffic source and router: flit, valid, busy back-pressure.
interface par_lfsr_source_if
  import par_lfsr_source_pkg::*;
;
  logic [DW-1:0] data;
  logic          valid;
  logic          busy;

  modport master (output data, valid, input busy);
  modport slave  (input data, valid, output busy);
endinterface

// File: rtl/par_lfsr_source_lfsr16.sv
// 16-bit Fibonacci LFSR, left-shifting, advancing only while enabled.
module lfsr16
  import par_lfsr_source_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] state
);
  always_ff @(posedge clk) begin
    if (reset)   state <= SEED;
    else if (en) state <= lfsr16_next(state);
  end
endmodule

// File: rtl/par_lfsr_source.sv
// LFSR-driven NoC injection source: per-cycle PIR decision, random non-self destination,
// small queue plus output register on a valid/busy handshake. Optional PAR_SRC_TIMESTAMP_EN
// replaces the sequence payload with the generation cycle.
module par_lfsr_source
  import par_lfsr_source_pkg::*;
#(
  parameter int          ID     = 0,
  parameter int          DESTS  = NUM_NODES,
  parameter int          PIR    = 255,
  parameter logic [15:0] SEED   = LFSR_DEFAULT_SEED,
  parameter int          QDEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send,
  par_lfsr_source_if.master     bus,
  output logic [CNT_SENT_W-1:0] sent_count,
  output logic [CNT_DROP_W-1:0] drop_count
);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? LFSR_DEFAULT_SEED : SEED;
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  logic [15:0]             lfsr;
  logic                    gen;
  logic [ADDR_BITS-1:0]    dest;
  logic [PAYLOAD_SIZE-1:0] payload;
  logic [DW-1:0]           flit;

  lfsr16 #(.SEED(SEED_EFF)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (send),
    .state (lfsr)
  );

  assign gen = send && ((PIR >= 255) || (int'(lfsr[7:0]) < PIR));

  always_comb begin
    int rnd;
    rnd = int'(lfsr[15:8]) % DESTS;
    if (rnd == ID) rnd = (rnd + 1) % DESTS;
    dest = ADDR_BITS'(rnd);
  end

  assign flit = {dest, payload};

  logic [DW-1:0] mem [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fcnt, held;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          xfer, room, push, pop;

  // The output register counts toward capacity; a transfer this edge frees its slot.
  assign xfer = out_valid && !bus.busy;
  assign held = fcnt + CW'(out_valid);
  assign room = (held < CW'(QDEPTH)) || xfer;
  assign push = gen && room;
  assign pop  = (fcnt != '0) && (!out_valid || xfer);

  assign bus.valid = out_valid;
  assign bus.data  = out_data;

`ifdef PAR_SRC_TIMESTAMP_EN
  logic [31:0] cycle;
  always_ff @(posedge clk) begin
    if (reset) cycle <= '0;
    else       cycle <= cycle + 32'd1;
  end
  assign payload = cycle[PAYLOAD_SIZE-1:0];
`else
  logic [PAYLOAD_SIZE-1:0] seq;
  always_ff @(posedge clk) begin
    if (reset)     seq <= '0;
    else if (push) seq <= seq + 1'b1;
  end
  assign payload = seq;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= flit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fcnt       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      sent_count <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        out_data <= mem[rd_ptr];
      end
      fcnt <= fcnt + CW'(push) - CW'(pop);
      if (pop)       out_valid <= 1'b1;
      else if (xfer) out_valid <= 1'b0;
      if (xfer) sent_count <= sent_count + 1'b1;
      if (gen && !room && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_par_lfsr_source.sv
// Bench for par_lfsr_source: three instances (full rate, partial rate with ID=4, never inject)
// share random send/busy/reset and are checked every cycle against a queue-based model.
module tb_par_lfsr_source;
  import par_lfsr_source_pkg::*;

  logic clk = 1'b0;
  logic reset, send, busy;
  bit   chk_en = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    int ones;
    ones = int'(s[15]) + int'(s[13]) + int'(s[12]) + int'(s[10]);
    return {s[14:0], 1'(ones % 2)};
  endfunction

  typedef struct {
    logic [DW-1:0] d;
    int            e;
  } ent_t;

  for (genvar i = 0; i < 3; i++) begin : g_inst
    localparam int          ID_I   = (i == 0) ? 0 : (i == 1) ? 4 : 2;
    localparam int          PIR_I  = (i == 0) ? 255 : (i == 1) ? 100 : 0;
    localparam logic [15:0] SEED_I = (i == 0) ? 16'hACE1 : (i == 1) ? 16'h1234 : 16'h0000;
    localparam logic [15:0] SEED_X = (SEED_I == 16'h0) ? 16'hACE1 : SEED_I;

    par_lfsr_source_if bus ();
    assign bus.busy = busy;

    logic [19:0]   sent;
    logic [15:0]   drop;
    logic [DW-1:0] dat;
    logic          vld;
    logic [15:0]   lfsr_obs;

    par_lfsr_source #(.ID(ID_I), .DESTS(9), .PIR(PIR_I), .SEED(SEED_I), .QDEPTH(4)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .send       (send),
      .bus        (bus),
      .sent_count (sent),
      .drop_count (drop)
    );

    assign dat      = bus.data;
    assign vld      = bus.valid;
    assign lfsr_obs = u_dut.u_lfsr.state;

    ent_t          q[$];
    ent_t          n;
    logic [15:0]   ml;
    logic          mvalid;
    logic [DW-1:0] mdata;
    int            mseq, mcyc, ecnt, msent, mdrop, rnd, pay;
    logic [8:0]    seen = '0;

    always @(posedge clk) begin
      if (reset) begin
        ml = SEED_X; q.delete();
        mseq = 0; mcyc = 0; ecnt = 0; msent = 0; mdrop = 0;
        mvalid = 1'b0; mdata = '0;
      end else begin
        ecnt++;
        if (mvalid && !busy) begin
          void'(q.pop_front());
          msent = (msent + 1) % (1 << 20);
        end
        if (send && (PIR_I == 255 || int'(ml[7:0]) < PIR_I)) begin
          rnd = int'(ml[15:8]) % 9;
          if (rnd == ID_I) rnd = (rnd + 1) % 9;
`ifdef PAR_SRC_TIMESTAMP_EN
          pay = mcyc % 256;
`else
          pay = mseq % 256;
`endif
          if (q.size() < 4) begin
            n.d = {4'(rnd), 8'(pay)};
            n.e = ecnt;
            q.push_back(n);
            mseq++;
          end else if (mdrop < 65535) mdrop++;
        end
        if (send) ml = ref_step(ml);
        mcyc++;
        mvalid = (q.size() > 0) && (q[0].e < ecnt);
        if (mvalid) mdata = q[0].d;
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        chk($sformatf("i%0d_valid", i), 32'(vld), 32'(mvalid));
        if (mvalid) chk($sformatf("i%0d_data", i), 32'(dat), 32'(mdata));
        chk($sformatf("i%0d_sent", i), 32'(sent), 32'(msent));
        chk($sformatf("i%0d_drop", i), 32'(drop), 32'(mdrop));
        chk($sformatf("i%0d_lfsr", i), 32'(lfsr_obs), 32'(ml));
        if (vld) begin
          chk($sformatf("i%0d_dest_range", i), 32'(dat[DW-1 -: ADDR_BITS] < 9), 32'd1);
          chk($sformatf("i%0d_dest_self", i), 32'(int'(dat[DW-1 -: ADDR_BITS]) != ID_I), 32'd1);
          if (dat[DW-1 -: ADDR_BITS] < 9) seen[dat[DW-1 -: ADDR_BITS]] = 1'b1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [15:0] d0;

  initial begin
    reset = 1'b1; send = 1'b0; busy = 1'b0;
    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    chk("reset_data", 32'(g_inst[0].dat), 32'd0);
    chk("reset_lfsr_seed0", 32'(g_inst[2].lfsr_obs), 32'hACE1);

    // Back-to-back at full rate, then drain.
    reset = 1'b0; send = 1'b1; busy = 1'b0;
    cyc(100);
    send = 1'b0;
    cyc(5);
    chk("b2b_sent", 32'(g_inst[0].sent), 32'd100);
    chk("b2b_drop", 32'(g_inst[0].drop), 32'd0);

    // Queue fill under sustained busy.
    reset = 1'b1;
    cyc(1);
    reset = 1'b0; busy = 1'b1; send = 1'b1;
    cyc(20);
    chk("full_drop", 32'(g_inst[0].drop), 32'd16);
    chk("full_valid", 32'(g_inst[0].vld), 32'd1);
    chk("full_payload", 32'(g_inst[0].dat[PAYLOAD_SIZE-1:0]), 32'd0);
    send = 1'b0; busy = 1'b0;
    cyc(6);
    chk("full_sent", 32'(g_inst[0].sent), 32'd4);

    // Full queue with one transfer edge alongside generation: no drop.
    busy = 1'b1; send = 1'b1;
    cyc(6);
    d0 = g_inst[0].drop;
    busy = 1'b0;
    cyc(1);
    chk("xfer_gen_nodrop", 32'(g_inst[0].drop), 32'(d0));
    busy = 1'b1;
    cyc(1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 4000; k++) begin
      send  = ($urandom_range(0, 7) != 0);
      busy  = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    reset = 1'b0;

    // Reset while a flit is presented and stalled.
    busy = 1'b1; send = 1'b1;
    cyc(3);
    chk("rst_pre_valid", 32'(g_inst[0].vld), 32'd1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0; send = 1'b0; busy = 1'b0;
    chk("rst_valid", 32'(g_inst[0].vld), 32'd0);
    chk("rst_sent", 32'(g_inst[0].sent), 32'd0);
    chk("rst_drop", 32'(g_inst[0].drop), 32'd0);
    chk("rst_lfsr", 32'(g_inst[1].lfsr_obs), 32'h1234);
    cyc(2);

    chk("seen_i0", 32'(g_inst[0].seen), 32'h1FE);
    chk("seen_i1", 32'(g_inst[1].seen), 32'h1EF);
    chk("seen_i2", 32'(g_inst[2].seen), 32'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
